// File: rtl/mem_axi_burst_splitter.sv
// AXI4-to-AXI3 burst splitter with DRAM window relocation.
// Splits upstream bursts into sub-bursts of at most MAX_LEN+1 beats,
// regenerates wlast per sub-burst and merges responses back into one
// upstream transaction. Read and write paths each allow one outstanding burst.
module mem_axi_burst_splitter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 6,
    parameter int unsigned MAX_LEN    = 15,
    parameter int unsigned WIN_BITS   = 28,
    parameter logic [31-WIN_BITS:0] WIN_BASE = 4'h1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    // upstream read address / data
    input  logic                      s_ar_valid,
    output logic                      s_ar_ready,
    input  logic [31:0]               s_ar_addr,
    input  logic [ID_WIDTH-1:0]       s_ar_id,
    input  logic [7:0]                s_ar_len,
    input  logic [2:0]                s_ar_size,
    input  logic [1:0]                s_ar_burst,
    output logic                      s_r_valid,
    input  logic                      s_r_ready,
    output logic [DATA_WIDTH-1:0]     s_r_data,
    output logic [ID_WIDTH-1:0]       s_r_id,
    output logic [1:0]                s_r_resp,
    output logic                      s_r_last,
    // upstream write address / data / response
    input  logic                      s_aw_valid,
    output logic                      s_aw_ready,
    input  logic [31:0]               s_aw_addr,
    input  logic [ID_WIDTH-1:0]       s_aw_id,
    input  logic [7:0]                s_aw_len,
    input  logic [2:0]                s_aw_size,
    input  logic [1:0]                s_aw_burst,
    input  logic                      s_w_valid,
    output logic                      s_w_ready,
    input  logic [DATA_WIDTH-1:0]     s_w_data,
    input  logic [DATA_WIDTH/8-1:0]   s_w_strb,
    input  logic                      s_w_last,
    output logic                      s_b_valid,
    input  logic                      s_b_ready,
    output logic [ID_WIDTH-1:0]       s_b_id,
    output logic [1:0]                s_b_resp,
    // downstream read address / data
    output logic                      m_ar_valid,
    input  logic                      m_ar_ready,
    output logic [31:0]               m_ar_addr,
    output logic [ID_WIDTH-1:0]       m_ar_id,
    output logic [3:0]                m_ar_len,
    output logic [2:0]                m_ar_size,
    output logic [1:0]                m_ar_burst,
    input  logic                      m_r_valid,
    output logic                      m_r_ready,
    input  logic [DATA_WIDTH-1:0]     m_r_data,
    input  logic [ID_WIDTH-1:0]       m_r_id,
    input  logic [1:0]                m_r_resp,
    input  logic                      m_r_last,
    // downstream write address / data / response
    output logic                      m_aw_valid,
    input  logic                      m_aw_ready,
    output logic [31:0]               m_aw_addr,
    output logic [ID_WIDTH-1:0]       m_aw_id,
    output logic [3:0]                m_aw_len,
    output logic [2:0]                m_aw_size,
    output logic [1:0]                m_aw_burst,
    output logic                      m_w_valid,
    input  logic                      m_w_ready,
    output logic [DATA_WIDTH-1:0]     m_w_data,
    output logic [DATA_WIDTH/8-1:0]   m_w_strb,
    output logic                      m_w_last,
    input  logic                      m_b_valid,
    output logic                      m_b_ready,
    input  logic [ID_WIDTH-1:0]       m_b_id,
    input  logic [1:0]                m_b_resp
);

    localparam int unsigned CNT_W = 9;

    typedef enum logic [1:0] {RIDLE, RADDR, RDATA} rstate_t;
    typedef enum logic [1:0] {WIDLE, WADDR, WRESP} wstate_t;

    // length of the next sub-burst (len encoding) given the remaining beats
    function automatic logic [3:0] sub_len(input logic [CNT_W-1:0] rem);
        if (rem > CNT_W'(MAX_LEN + 1)) sub_len = 4'(MAX_LEN);
        else                           sub_len = 4'(rem - CNT_W'(1));
    endfunction

    function automatic logic [31:0] map_addr(input logic [WIN_BITS-1:0] a);
        map_addr = {WIN_BASE, a};
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst,
                                              input logic [3:0] len, input logic [2:0] size);
        next_addr = (burst == 2'b01) ? a + ((32'(len) + 32'd1) << size) : a;
    endfunction

    // ---------------- read path ----------------
    rstate_t          r_state;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_rem, r_subs, r_lasts;
    logic [CNT_W-1:0] ar_rem_next;
    logic [31:0]      ar_addr_next;
    logic             r_busy, r_final, r_final_hs;

    assign ar_rem_next  = r_rem - (CNT_W'(m_ar_len) + CNT_W'(1));
    assign ar_addr_next = next_addr(r_addr, m_ar_burst, m_ar_len, m_ar_size);
    assign r_busy       = (r_state != RIDLE);
    assign r_final      = (r_state == RDATA) && (r_lasts == r_subs - CNT_W'(1));
    assign m_r_ready    = s_r_ready && r_busy;
    assign s_r_valid    = m_r_valid && r_busy;
    assign s_r_data     = m_r_data;
    assign s_r_resp     = m_r_resp;
    assign s_r_id       = m_ar_id;
    assign s_r_last     = m_r_last && r_final;
    assign r_final_hs   = s_r_valid && s_r_ready && s_r_last;

    // read FSM: accept AR, issue sub-burst ARs, wait for the final beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RIDLE;
            s_ar_ready <= 1'b0;
            m_ar_valid <= 1'b0;
            m_ar_addr  <= '0;
            m_ar_id    <= '0;
            m_ar_len   <= '0;
            m_ar_size  <= '0;
            m_ar_burst <= '0;
            r_addr     <= '0;
            r_rem      <= '0;
            r_subs     <= '0;
            r_lasts    <= '0;
        end else begin
            if (m_r_valid && m_r_ready && m_r_last) r_lasts <= r_lasts + CNT_W'(1);
            case (r_state)
                RIDLE: begin
                    s_ar_ready <= 1'b1;
                    if (s_ar_valid && s_ar_ready) begin
                        s_ar_ready <= 1'b0;
                        m_ar_valid <= 1'b1;
                        m_ar_addr  <= map_addr(s_ar_addr[WIN_BITS-1:0]);
                        m_ar_len   <= sub_len(CNT_W'(s_ar_len) + CNT_W'(1));
                        m_ar_id    <= s_ar_id;
                        m_ar_size  <= s_ar_size;
                        m_ar_burst <= s_ar_burst;
                        r_addr     <= s_ar_addr;
                        r_rem      <= CNT_W'(s_ar_len) + CNT_W'(1);
                        r_subs     <= '0;
                        r_lasts    <= '0;
                        r_state    <= RADDR;
                    end
                end
                RADDR: begin
                    if (m_ar_valid && m_ar_ready) begin
                        r_subs <= r_subs + CNT_W'(1);
                        r_rem  <= ar_rem_next;
                        r_addr <= ar_addr_next;
                        if (ar_rem_next == '0) begin
                            m_ar_valid <= 1'b0;
                            r_state    <= RDATA;
                        end else begin
                            m_ar_addr <= map_addr(ar_addr_next[WIN_BITS-1:0]);
                            m_ar_len  <= sub_len(ar_rem_next);
                        end
                    end
                end
                RDATA: begin
                    if (r_final_hs) begin
                        s_ar_ready <= 1'b1;
                        r_state    <= RIDLE;
                    end
                end
                default: r_state <= RIDLE;
            endcase
        end
    end

    // ---------------- write path ----------------
    wstate_t          w_state;
    logic [31:0]      w_addr;
    logic [CNT_W-1:0] w_rem, w_subs, w_bcnt, w_total, w_issued, w_fwd;
    logic [CNT_W-1:0] aw_rem_next;
    logic [31:0]      aw_addr_next;
    logic [3:0]       w_sub_beat;
    logic [1:0]       w_resp_acc, b_merged;
    logic             w_permit, w_hs, w_last_b;

    assign aw_rem_next  = w_rem - (CNT_W'(m_aw_len) + CNT_W'(1));
    assign aw_addr_next = next_addr(w_addr, m_aw_burst, m_aw_len, m_aw_size);
    assign w_permit     = (w_issued > w_fwd);
    assign m_w_valid    = s_w_valid && w_permit;
    assign s_w_ready    = m_w_ready && w_permit;
    assign m_w_data     = s_w_data;
    assign m_w_strb     = s_w_strb;
    assign m_w_last     = (w_sub_beat == 4'(MAX_LEN)) || (w_fwd == w_total - CNT_W'(1));
    assign w_hs         = m_w_valid && m_w_ready;
    assign w_last_b     = (w_state == WRESP) && (w_bcnt == w_subs - CNT_W'(1));
    assign b_merged     = (m_b_resp > w_resp_acc) ? m_b_resp : w_resp_acc;
    assign m_b_ready    = w_last_b ? s_b_ready : 1'b1;
    assign s_b_valid    = m_b_valid && w_last_b;
    assign s_b_id       = m_aw_id;
    assign s_b_resp     = b_merged;

    // write FSM: accept AW, issue sub-burst AWs, track W beats and merge B
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state    <= WIDLE;
            s_aw_ready <= 1'b0;
            m_aw_valid <= 1'b0;
            m_aw_addr  <= '0;
            m_aw_id    <= '0;
            m_aw_len   <= '0;
            m_aw_size  <= '0;
            m_aw_burst <= '0;
            w_addr     <= '0;
            w_rem      <= '0;
            w_subs     <= '0;
            w_bcnt     <= '0;
            w_total    <= '0;
            w_issued   <= '0;
            w_fwd      <= '0;
            w_sub_beat <= '0;
            w_resp_acc <= '0;
        end else begin
            if (w_hs) begin
                w_fwd      <= w_fwd + CNT_W'(1);
                w_sub_beat <= m_w_last ? 4'd0 : w_sub_beat + 4'd1;
            end
            if (m_b_valid && m_b_ready && !w_last_b) begin
                w_bcnt     <= w_bcnt + CNT_W'(1);
                w_resp_acc <= b_merged;
            end
            case (w_state)
                WIDLE: begin
                    s_aw_ready <= 1'b1;
                    if (s_aw_valid && s_aw_ready) begin
                        s_aw_ready <= 1'b0;
                        m_aw_valid <= 1'b1;
                        m_aw_addr  <= map_addr(s_aw_addr[WIN_BITS-1:0]);
                        m_aw_len   <= sub_len(CNT_W'(s_aw_len) + CNT_W'(1));
                        m_aw_id    <= s_aw_id;
                        m_aw_size  <= s_aw_size;
                        m_aw_burst <= s_aw_burst;
                        w_addr     <= s_aw_addr;
                        w_rem      <= CNT_W'(s_aw_len) + CNT_W'(1);
                        w_total    <= CNT_W'(s_aw_len) + CNT_W'(1);
                        w_subs     <= '0;
                        w_bcnt     <= '0;
                        w_issued   <= '0;
                        w_fwd      <= '0;
                        w_sub_beat <= '0;
                        w_resp_acc <= '0;
                        w_state    <= WADDR;
                    end
                end
                WADDR: begin
                    if (m_aw_valid && m_aw_ready) begin
                        w_subs   <= w_subs + CNT_W'(1);
                        w_issued <= w_issued + CNT_W'(m_aw_len) + CNT_W'(1);
                        w_rem    <= aw_rem_next;
                        w_addr   <= aw_addr_next;
                        if (aw_rem_next == '0) begin
                            m_aw_valid <= 1'b0;
                            w_state    <= WRESP;
                        end else begin
                            m_aw_addr <= map_addr(aw_addr_next[WIN_BITS-1:0]);
                            m_aw_len  <= sub_len(aw_rem_next);
                        end
                    end
                end
                WRESP: begin
                    if (s_b_valid && s_b_ready) begin
                        s_aw_ready <= 1'b1;
                        w_state    <= WIDLE;
                    end
                end
                default: w_state <= WIDLE;
            endcase
        end
    end

    // downstream ids are not checked and upstream wlast is regenerated
    logic unused_ok;
    assign unused_ok = ^{m_r_id, m_b_id, s_w_last};

endmodule

// File: tb/tb_mem_axi_burst_splitter.sv
// Randomized bench for mem_axi_burst_splitter: an upstream master and a
// downstream slave model, with expected sub-bursts derived arithmetically.
module tb_mem_axi_burst_splitter;

    localparam int unsigned DW  = 64;
    localparam int unsigned IDW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic s_ar_valid, s_ar_ready; logic [31:0] s_ar_addr; logic [IDW-1:0] s_ar_id;
    logic [7:0] s_ar_len; logic [2:0] s_ar_size; logic [1:0] s_ar_burst;
    logic s_r_valid, s_r_ready; logic [DW-1:0] s_r_data; logic [IDW-1:0] s_r_id;
    logic [1:0] s_r_resp; logic s_r_last;
    logic s_aw_valid, s_aw_ready; logic [31:0] s_aw_addr; logic [IDW-1:0] s_aw_id;
    logic [7:0] s_aw_len; logic [2:0] s_aw_size; logic [1:0] s_aw_burst;
    logic s_w_valid, s_w_ready; logic [DW-1:0] s_w_data; logic [DW/8-1:0] s_w_strb; logic s_w_last;
    logic s_b_valid, s_b_ready; logic [IDW-1:0] s_b_id; logic [1:0] s_b_resp;
    logic m_ar_valid, m_ar_ready; logic [31:0] m_ar_addr; logic [IDW-1:0] m_ar_id;
    logic [3:0] m_ar_len; logic [2:0] m_ar_size; logic [1:0] m_ar_burst;
    logic m_r_valid, m_r_ready; logic [DW-1:0] m_r_data; logic [IDW-1:0] m_r_id;
    logic [1:0] m_r_resp; logic m_r_last;
    logic m_aw_valid, m_aw_ready; logic [31:0] m_aw_addr; logic [IDW-1:0] m_aw_id;
    logic [3:0] m_aw_len; logic [2:0] m_aw_size; logic [1:0] m_aw_burst;
    logic m_w_valid, m_w_ready; logic [DW-1:0] m_w_data; logic [DW/8-1:0] m_w_strb; logic m_w_last;
    logic m_b_valid, m_b_ready; logic [IDW-1:0] m_b_id; logic [1:0] m_b_resp;

    mem_axi_burst_splitter dut (
        .clk(clk), .reset_n(reset_n),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
        .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_id(s_r_id),
        .s_r_resp(s_r_resp), .s_r_last(s_r_last),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id),
        .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
        .s_w_last(s_w_last),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
        .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_id(m_r_id),
        .m_r_resp(m_r_resp), .m_r_last(m_r_last),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id),
        .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
        .m_w_last(m_w_last),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: expected downstream sub-bursts for one upstream burst
    logic [31:0] exp_addr[$];
    logic [3:0]  exp_len[$];
    logic [1:0]  bresp_tab[16];

    task automatic build_model(input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        int rem;
        logic [31:0] a;
        rem = int'(len) + 1;
        a = addr;
        exp_addr.delete();
        exp_len.delete();
        while (rem > 0) begin
            int n;
            n = (rem > 16) ? 16 : rem;
            exp_addr.push_back({4'h1, a[27:0]});
            exp_len.push_back(4'(n - 1));
            if (burst == 2'b01) a = a + 32'(n << size);
            rem -= n;
        end
    endtask

    task automatic drive_idle();
        s_ar_valid = 0; s_ar_addr = 0; s_ar_id = 0; s_ar_len = 0; s_ar_size = 0; s_ar_burst = 0;
        s_r_ready = 0;
        s_aw_valid = 0; s_aw_addr = 0; s_aw_id = 0; s_aw_len = 0; s_aw_size = 0; s_aw_burst = 0;
        s_w_valid = 0; s_w_data = 0; s_w_strb = 0; s_w_last = 0; s_b_ready = 0;
        m_ar_ready = 0; m_r_valid = 0; m_r_data = 0; m_r_id = 0; m_r_resp = 0; m_r_last = 0;
        m_aw_ready = 0; m_w_ready = 0; m_b_valid = 0; m_b_id = 0; m_b_resp = 0;
    endtask

    task automatic apply_reset();
        drive_idle();
        reset_n = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
        check("rst_m_aw_valid", 64'(m_aw_valid), 64'd0);
        check("rst_s_ar_ready", 64'(s_ar_ready), 64'd0);
        check("rst_s_aw_ready", 64'(s_aw_ready), 64'd0);
        @(negedge clk);
        reset_n = 1;
        #1;
        check("rel_s_ar_ready_low", 64'(s_ar_ready), 64'd0);
        @(negedge clk);
        #1;
        check("rel_s_ar_ready_high", 64'(s_ar_ready), 64'd1);
        check("rel_s_aw_ready_high", 64'(s_aw_ready), 64'd1);
    endtask

    task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [5:0] id, input int ar_delay,
                            input int abort_after);
        int nbeats, k, up, sb, cyc;
        bit ar_acc, r_pres, done, ready_bad;
        logic [31:0] q_addr[$];
        int q_len[$];
        nbeats = int'(len) + 1;
        k = 0; up = 0; sb = 0; cyc = 0;
        ar_acc = 0; r_pres = 0; done = 0; ready_bad = 0;
        build_model(addr, len, size, burst);
        while (!done && cyc < 4000) begin
            @(negedge clk);
            s_ar_valid = !ar_acc; s_ar_addr = addr; s_ar_len = len; s_ar_size = size;
            s_ar_burst = burst; s_ar_id = id;
            m_ar_ready = (cyc >= ar_delay) ? ($urandom_range(0, 3) != 0) : 1'b0;
            if (!r_pres && q_addr.size() > 0 && $urandom_range(0, 3) != 0) r_pres = 1;
            m_r_valid = r_pres;
            m_r_id = id; m_r_resp = 2'b00;
            if (r_pres) begin
                m_r_data = {q_addr[0], 32'(sb)};
                m_r_last = (sb == q_len[0]);
            end else begin
                m_r_data = '0;
                m_r_last = 1'b0;
            end
            s_r_ready = ($urandom_range(0, 3) != 0);
            #1;
            cyc++;
            if (ar_acc && s_ar_ready) ready_bad = 1;
            if (s_ar_valid && s_ar_ready) ar_acc = 1;
            if (m_ar_valid && m_ar_ready) begin
                if (k < exp_addr.size()) begin
                    check("ar_addr", 64'(m_ar_addr), 64'(exp_addr[k]));
                    check("ar_len", 64'(m_ar_len), 64'(exp_len[k]));
                end
                check("ar_id", 64'(m_ar_id), 64'(id));
                check("ar_burst", 64'(m_ar_burst), 64'(burst));
                q_addr.push_back(m_ar_addr);
                q_len.push_back(int'(m_ar_len));
                k++;
            end
            if (s_r_valid && s_r_ready) begin
                check("r_data", s_r_data, {exp_addr[(up / 16) % exp_addr.size()], 32'(up % 16)});
                check("r_last", 64'(s_r_last), 64'(up == nbeats - 1));
                check("r_id", 64'(s_r_id), 64'(id));
                up++;
                if (up == nbeats) done = 1;
            end
            if (m_r_valid && m_r_ready) begin
                r_pres = 0;
                if (sb == q_len[0]) begin
                    void'(q_addr.pop_front());
                    void'(q_len.pop_front());
                    sb = 0;
                end else begin
                    sb++;
                end
            end
            if (abort_after > 0 && up == abort_after) begin
                m_r_valid = 1'b1;
                reset_n = 0;
                #1;
                check("abort_s_r_valid", 64'(s_r_valid), 64'd0);
                check("abort_m_ar_valid", 64'(m_ar_valid), 64'd0);
                check("abort_s_ar_ready", 64'(s_ar_ready), 64'd0);
                apply_reset();
                return;
            end
        end
        check("rd_done", 64'(done), 64'd1);
        check("rd_ar_count", 64'(k), 64'(exp_addr.size()));
        check("rd_ar_ready_busy", 64'(ready_bad), 64'd0);
        @(negedge clk);
        drive_idle();
        #1;
        check("rd_ar_ready_after", 64'(s_ar_ready), 64'd1);
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [5:0] id, input int aw_delay);
        int nbeats, nsub, k, aw_beats, wi, wrx, bhs, cyc;
        bit aw_acc, w_pres, b_pres, done, ready_bad, order_bad;
        logic [1:0] exp_resp;
        logic [63:0] wdata[256];
        logic [7:0]  wstrb[256];
        logic [1:0]  bq[$];
        nbeats = int'(len) + 1;
        build_model(addr, len, size, burst);
        nsub = exp_addr.size();
        exp_resp = 2'b00;
        for (int i = 0; i < nsub; i++) if (bresp_tab[i] > exp_resp) exp_resp = bresp_tab[i];
        for (int i = 0; i < nbeats; i++) begin
            wdata[i] = {$urandom, $urandom};
            wstrb[i] = 8'($urandom);
        end
        k = 0; aw_beats = 0; wi = 0; wrx = 0; bhs = 0; cyc = 0;
        aw_acc = 0; w_pres = 0; b_pres = 0; done = 0; ready_bad = 0; order_bad = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            s_aw_valid = !aw_acc; s_aw_addr = addr; s_aw_len = len; s_aw_size = size;
            s_aw_burst = burst; s_aw_id = id;
            m_aw_ready = (cyc >= aw_delay) ? ($urandom_range(0, 3) != 0) : 1'b0;
            if (!w_pres && wi < nbeats && $urandom_range(0, 3) != 0) w_pres = 1;
            s_w_valid = w_pres;
            s_w_data = wdata[wi % 256]; s_w_strb = wstrb[wi % 256]; s_w_last = (wi == nbeats - 1);
            m_w_ready = ($urandom_range(0, 3) != 0);
            if (!b_pres && bq.size() > 0 && $urandom_range(0, 2) != 0) b_pres = 1;
            m_b_valid = b_pres; m_b_id = id;
            m_b_resp = b_pres ? bq[0] : 2'b00;
            s_b_ready = ($urandom_range(0, 2) != 0);
            #1;
            cyc++;
            if (aw_acc && s_aw_ready) ready_bad = 1;
            if (s_aw_valid && s_aw_ready) aw_acc = 1;
            if (m_w_valid && wrx >= aw_beats) order_bad = 1;
            if (m_aw_valid && m_aw_ready) begin
                if (k < nsub) begin
                    check("aw_addr", 64'(m_aw_addr), 64'(exp_addr[k]));
                    check("aw_len", 64'(m_aw_len), 64'(exp_len[k]));
                end
                check("aw_id", 64'(m_aw_id), 64'(id));
                aw_beats += int'(m_aw_len) + 1;
                k++;
            end
            if (s_w_valid && s_w_ready) begin
                wi++;
                w_pres = 0;
            end
            if (m_w_valid && m_w_ready) begin
                bit exp_last;
                exp_last = ((wrx % 16) == 15) || (wrx == nbeats - 1);
                check("w_data", m_w_data, wdata[wrx % 256]);
                check("w_strb", 64'(m_w_strb), 64'(wstrb[wrx % 256]));
                check("w_last", 64'(m_w_last), 64'(exp_last));
                if (exp_last) bq.push_back(bresp_tab[(wrx / 16) % 16]);
                wrx++;
            end
            if (m_b_valid && m_b_ready) begin
                void'(bq.pop_front());
                b_pres = 0;
                bhs++;
            end
            if (s_b_valid && s_b_ready) begin
                check("b_resp", 64'(s_b_resp), 64'(exp_resp));
                check("b_id", 64'(s_b_id), 64'(id));
                check("b_after_all_mb", 64'(bhs), 64'(nsub));
                done = 1;
            end
        end
        check("wr_done", 64'(done), 64'd1);
        check("wr_aw_count", 64'(k), 64'(nsub));
        check("wr_w_before_aw", 64'(order_bad), 64'd0);
        check("wr_aw_ready_busy", 64'(ready_bad), 64'd0);
        check("wr_w_count", 64'(wrx), 64'(nbeats));
        @(negedge clk);
        drive_idle();
        #1;
        check("wr_aw_ready_after", 64'(s_aw_ready), 64'd1);
        check("wr_b_valid_after", 64'(s_b_valid), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0;
        drive_idle();
        for (int i = 0; i < 16; i++) bresp_tab[i] = 2'b00;
        apply_reset();

        // directed scenarios
        run_read(32'h0000_1000, 8'd63, 3'd3, 2'b01, 6'h05, 0, 0);
        run_read(32'h0000_2000, 8'd20, 3'd3, 2'b01, 6'h11, 0, 0);
        run_write(32'h0000_3000, 8'd31, 3'd3, 2'b01, 6'h22, 5);
        bresp_tab[0] = 2'b00; bresp_tab[1] = 2'b10;
        run_write(32'h0400_0000, 8'd31, 3'd3, 2'b01, 6'h2a, 0);
        bresp_tab[1] = 2'b00;
        run_read(32'h0000_4008, 8'd0, 3'd3, 2'b01, 6'h01, 0, 0);
        run_write(32'h0000_5008, 8'd0, 3'd3, 2'b01, 6'h02, 0);
        run_read(32'h0000_6000, 8'd31, 3'd3, 2'b00, 6'h03, 0, 0);
        run_write(32'h0000_7000, 8'd31, 3'd3, 2'b00, 6'h04, 0);
        run_read(32'hF000_8000, 8'd255, 3'd3, 2'b01, 6'h3f, 0, 0);
        run_write(32'h0000_9000, 8'd47, 3'd2, 2'b01, 6'h06, 2);
        run_read(32'h0000_A010, 8'd7, 3'd3, 2'b10, 6'h07, 0, 0);

        // randomized bursts
        for (int t = 0; t < 10; t++) begin
            logic [31:0] ra;
            logic [7:0]  rl;
            logic [2:0]  rs;
            logic [1:0]  rb;
            ra = $urandom;
            rl = 8'($urandom_range(0, 80));
            rs = 3'($urandom_range(0, 3));
            rb = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
            for (int i = 0; i < 16; i++) bresp_tab[i] = 2'($urandom);
            if (t % 2 == 0) run_read(ra, rl, rs, rb, 6'($urandom), int'($urandom_range(0, 4)), 0);
            else            run_write(ra, rl, rs, rb, 6'($urandom), int'($urandom_range(0, 4)));
        end

        // reset in the middle of a read, then the first read again
        run_read(32'h0000_1000, 8'd63, 3'd3, 2'b01, 6'h05, 0, 7);
        run_read(32'h0000_1000, 8'd63, 3'd3, 2'b01, 6'h05, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_axi_burst_splitter.md
Name: mem_axi_burst_splitter

Overview:
- Sits between the Rocket top-level AXI4 memory master port and the Zynq S_AXI high-performance slave port, replacing the direct combinational address remap.
- Converts AXI4 bursts (len up to 255) into AXI3-legal sub-bursts (len ≤ MAX_LEN).
- Relocates addresses into the DRAM window reserved for Rocket.
- Regenerates wlast per sub-burst and merges sub-burst responses so the upstream master sees one AXI4 transaction.

Parameters:
- DATA_WIDTH, 64, R/W data width; strobe width is DATA_WIDTH/8.
- ID_WIDTH, 6, AXI ID width on both sides.
- MAX_LEN, 15, maximum downstream len field (beats-1).
- WIN_BITS, 28, number of low input address bits kept.
- WIN_BASE, 4'h1, value placed in addr[31:WIN_BITS] of every downstream address.

Ports:
- clk  in  1  host clock; all logic is single-domain.
- reset_n  in  1  asynchronous active-low reset.
- s_ar_valid/ready/addr/id/len/size/burst  in,out,in,in,in,in,in  1,1,32,ID,8,3,2  upstream read address.
- s_r_valid/ready/data/id/resp/last  out,in,out,out,out,out  1,1,DW,ID,2,1  upstream read data.
- s_aw_valid/ready/addr/id/len/size/burst  in,out,in,in,in,in,in  1,1,32,ID,8,3,2  upstream write address.
- s_w_valid/ready/data/strb/last  in,out,in,in,in  1,1,DW,DW/8,1  upstream write data; s_w_last is ignored.
- s_b_valid/ready/id/resp  out,in,out,out  1,1,ID,2  upstream write response.
- m_ar_*, m_r_*, m_aw_*, m_w_*, m_b_*  mirror of the s_* ports with directions reversed  downstream to the Zynq HP port. m_ar_len and m_aw_len are 4 bits.

Behaviour:
- Reset (async assert, sync deassert by the caller): all *_valid low, s_ar_ready/s_aw_ready low for one cycle after release and then high in IDLE, counters 0, FSMs in IDLE.
- Address mapping: m_addr = {WIN_BASE, cur_addr[WIN_BITS-1:0]}.
- Read and write paths are independent. Each path allows exactly one upstream transaction outstanding.
- Read FSM RIDLE:
  - s_ar_ready=1.
  - On handshake, latch addr/id/size/burst and set rem = len+1 beats. Go to RADDR.
- Read FSM RADDR:
  - Drive m_ar_valid with sub_len = min(rem, MAX_LEN+1)-1.
  - On m_ar handshake: rem -= sub_len+1 and record sub_len+1 in a per-sub-burst beat count.
  - INCR: addr += (sub_len+1)<<size.
  - FIXED: addr is unchanged.
  - WRAP: upstream len ≤ 15 by protocol, so the burst passes through as one sub-burst.
  - When rem reaches 0, go to RDATA. Address issuing may run ahead of data.
- R channel:
  - Combinational pass-through of valid, ready, data and resp.
  - s_r_id is the latched id.
  - s_r_last = m_r_last AND this is the final sub-burst. Final is tracked by counting m_r_last against the number of sub-bursts issued.
  - On the final beat handshake, go to RIDLE. s_ar_ready asserts the next cycle.
- Write FSM WIDLE → WADDR: same splitting as the read path.
- W channel:
  - Beats are forwarded only while issued_aw_beats > forwarded_w_beats. A W beat never precedes its AW.
  - A beat counter regenerates m_w_last at the end of each sub-burst.
  - s_w_ready = m_w_ready AND forwarding permitted.
- B channel (WRESP):
  - Every m_b except the last is consumed internally (m_b_ready=1).
  - Merged resp is the maximum of all sub-burst resps (SLVERR/DECERR dominate).
  - The last m_b is held until s_b handshake, with m_b_ready = s_b_ready for it.
  - Then go to WIDLE.
- Boundaries:
  - len+1 exactly divisible by MAX_LEN+1: no zero-length tail sub-burst.
  - len=0: one sub-burst with len 0.
  - len=255: 16 sub-bursts.
  - Downstream m_r_valid arriving the same cycle as the final m_ar handshake is legal.
- Reset mid-burst aborts immediately. No partial response is completed; the upstream master is reset together with this block.

Test Plan:
- AR addr=0x0000_1000, len=63, size=3, INCR -> 4 m_ar with len=15 at 0x1000_1000, 0x1000_1080, 0x1000_1100, 0x1000_1180; 64 R beats; s_r_last only on beat 64.
- AR len=20 -> m_ar lens 15 then 4; second addr = first+0x80; s_ar_ready low until beat 21 is accepted.
- AW len=31 with m_aw_ready delayed 5 cycles -> no m_w_valid before the first m_aw handshake; m_w_last on beats 16 and 32; one s_b after the second m_b.
- Write with sub-burst B resps OKAY, SLVERR -> single s_b with resp=2'b10 and the original id.
- len=0 read and write, and FIXED len=31 -> one sub-burst for len=0; FIXED issues two sub-bursts with identical addresses.
- Assert reset_n low during RDATA after beat 7 -> all valids drop asynchronously; after release the first AR behaves per scenario 1.
